priority_8x3_encoder: RTL and testbench
=======================================

Name: priority_8x3_encoder

Overview:
- 8-input to 3-bit binary priority encoder with a registered output stage.
- Reports the index of the highest-priority asserted request bit, plus a valid flag.
- Sits between request-collection logic (interrupt lines, arbiter requests) and downstream index consumers.
- Synchronous to one clock; asynchronous active-low reset.

Parameters:
- LSB_PRIORITY, 0, 0 = bit 7 has highest priority (MSB wins); 1 = bit 0 has highest priority (LSB wins).
- ZERO_CODE, 3'b000, index value driven on i when no request bit is set.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- y  input  8  request vector; bit k set = request k active.
- i  output  3  encoded index of the winning request (registered).
- valid  output  1  1 when at least one bit of y was set in the sampled cycle (registered).

Behaviour:
- Reset: while rst_n = 0, i = ZERO_CODE and valid = 0, immediately and independent of clk. Deassertion takes effect at the next rising edge.
- Latency: one cycle. y sampled at rising edge N; i/valid reflect that sample from edge N until edge N+1.
- Priority with LSB_PRIORITY = 0: i = index of the highest set bit. Example: y = 8'b10000011 gives i = 7.
- Priority with LSB_PRIORITY = 1: i = index of the lowest set bit. Example: 8'b10000011 gives i = 0.
- Zero input: y = 0 gives valid = 0 and i = ZERO_CODE. Consumers must qualify i with valid, because y = 8'b00000001 also yields i = 0 (with MSB priority).
- Single-hot input: i equals the bit position regardless of LSB_PRIORITY.
- Register behaviour: i/valid update every cycle with no enable. Output is held only between edges.
- No combinational path from y to the outputs.
- Reset mid-operation: outputs clear asynchronously. The first post-reset edge samples y normally.
- X on y: implementation-defined, no requirement. The bench drives only known values.

Optional Feature:
- Macro: PRIO_ENC_ONEHOT_EN.
- Defined: adds output port grant [7:0], registered alongside i. It is the one-hot of the winning bit and 8'h00 when valid = 0. Resets to 8'h00.
- Example: y = 8'b00111000 with MSB priority gives grant = 8'b00100000.
- Undefined: grant port and its register are absent; all other behaviour is identical.

Decomposition:
- Package priority_enc_pkg holds:
  - REQ_W = 8, IDX_W = 3 (IDX_W derived as $clog2(REQ_W));
  - localparam default ZERO_CODE;
  - function reverse8 used to implement LSB_PRIORITY by bit-reversal of y and the resulting index.
- One sub-module: prio_enc_core. It is purely combinational: y, returning idx[2:0], any, and optional onehot[7:0]. The top adds the output register stage and reset.

Test Plan:
- Reset: rst_n = 0 mid-cycle with y = 8'hFF -> i = 0, valid = 0 immediately (no clock edge needed). Release, then next edge -> i = 7, valid = 1.
- Walking one: y = 8'h01, 02, 04 ... 80 on successive edges -> i = 0, 1, 2 ... 7 one cycle later, valid = 1 each. Then y = 8'h00 -> valid = 0, i = 0.
- Multi-bit, MSB priority: y = 8'b10000011 -> 7; 8'b00111000 -> 5; 8'b00001111 -> 3; 8'b01010101 -> 6. All with valid = 1.
- LSB_PRIORITY = 1 instance, same vectors: 8'b10000011 -> 0; 8'b00111000 -> 3; 8'b00001111 -> 0; 8'b01010101 -> 0.
- Latency check: change y between edges -> i unchanged until the next rising edge. Outputs equal the combinational model delayed exactly one cycle over a 1000-cycle random run.
- With PRIO_ENC_ONEHOT_EN defined: y = 8'b01010101 -> grant = 8'b01000000. y = 0 -> grant = 8'h00. Reset -> grant = 8'h00.

Source files
------------

// File: rtl/priority_enc_pkg.sv
// Shared widths, default empty-vector code and the bit-reversal helper for the priority encoder.
package priority_enc_pkg;

    localparam int unsigned REQ_W = 8;
    localparam int unsigned IDX_W = $clog2(REQ_W);

    localparam logic [IDX_W-1:0] ZERO_CODE_DEFAULT = IDX_W'(0);

    // Mirrors a request vector so that an LSB-first search reuses the MSB-first encoder.
    function automatic logic [REQ_W-1:0] reverse8(input logic [REQ_W-1:0] v);
        logic [REQ_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < REQ_W; k++) begin
            r[k] = v[REQ_W-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority search over the request vector; all outputs are unregistered.
// PRIO_ENC_ONEHOT_EN adds the one-hot grant output.
module prio_enc_core
    import priority_enc_pkg::*;
#(
    parameter bit LSB_PRIORITY = 1'b0
) (
    input  logic [REQ_W-1:0] y,
    output logic [IDX_W-1:0] idx_c,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [REQ_W-1:0] onehot_c,
`endif
    output logic             any_c
);

    logic [REQ_W-1:0] y_ord;
    logic [IDX_W-1:0] idx_ord;

    // Highest set bit of the (optionally mirrored) vector; later iterations override earlier ones.
    always_comb begin
        y_ord   = LSB_PRIORITY ? reverse8(y) : y;
        idx_ord = '0;
        for (int unsigned k = 0; k < REQ_W; k++) begin
            if (y_ord[k]) begin
                idx_ord = IDX_W'(k);
            end
        end
    end

    assign idx_c = LSB_PRIORITY ? (IDX_W'(REQ_W - 1) - idx_ord) : idx_ord;
    assign any_c = |y;

`ifdef PRIO_ENC_ONEHOT_EN
    assign onehot_c = any_c ? (REQ_W'(1) << idx_c) : '0;
`endif

endmodule

// File: rtl/priority_8x3_encoder.sv
// 8-to-3 priority encoder with a single registered output stage and valid flag.
// PRIO_ENC_ONEHOT_EN adds a registered one-hot grant output.
module priority_8x3_encoder
    import priority_enc_pkg::*;
#(
    parameter bit               LSB_PRIORITY = 1'b0,
    parameter logic [IDX_W-1:0] ZERO_CODE    = ZERO_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_W-1:0] y,
    output logic [IDX_W-1:0] i,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [REQ_W-1:0] grant,
`endif
    output logic             valid
);

    logic [IDX_W-1:0] idx_c;
    logic             any_c;
    logic [IDX_W-1:0] i_d, i_q;
    logic             valid_d, valid_q;

`ifdef PRIO_ENC_ONEHOT_EN
    logic [REQ_W-1:0] onehot_c;
    logic [REQ_W-1:0] grant_d, grant_q;
`endif

    prio_enc_core #(
        .LSB_PRIORITY(LSB_PRIORITY)
    ) u_core (
        .y        (y),
        .idx_c    (idx_c),
`ifdef PRIO_ENC_ONEHOT_EN
        .onehot_c (onehot_c),
`endif
        .any_c    (any_c)
    );

    // Empty request vector reports ZERO_CODE so consumers see a fixed index when invalid.
    always_comb begin
        i_d     = ZERO_CODE;
        valid_d = any_c;
        if (any_c) begin
            i_d = idx_c;
        end
`ifdef PRIO_ENC_ONEHOT_EN
        grant_d = onehot_c;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q     <= ZERO_CODE;
            valid_q <= 1'b0;
`ifdef PRIO_ENC_ONEHOT_EN
            grant_q <= '0;
`endif
        end else begin
            i_q     <= i_d;
            valid_q <= valid_d;
`ifdef PRIO_ENC_ONEHOT_EN
            grant_q <= grant_d;
`endif
        end
    end

    assign i     = i_q;
    assign valid = valid_q;
`ifdef PRIO_ENC_ONEHOT_EN
    assign grant = grant_q;
`endif

endmodule

// File: tb/tb_priority_8x3_encoder.sv
// Scoreboard bench for priority_8x3_encoder: MSB-priority and LSB-priority instances side by side.
// Build with PRIO_ENC_ONEHOT_EN to also check grant.
module tb_priority_8x3_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] y;
    logic [2:0] i_msb, i_lsb;
    logic       valid_msb, valid_lsb;
    logic [7:0] grant_msb, grant_lsb;

    int n_cmp;
    int n_err;

    // Expected word packs {valid, i, grant}.
    logic [11:0] q_msb[$];
    logic [11:0] q_lsb[$];
    logic [11:0] last_msb, last_lsb;

    priority_8x3_encoder #(.LSB_PRIORITY(1'b0)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .i     (i_msb),
`ifdef PRIO_ENC_ONEHOT_EN
        .grant (grant_msb),
`endif
        .valid (valid_msb)
    );

    priority_8x3_encoder #(.LSB_PRIORITY(1'b1)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .i     (i_lsb),
`ifdef PRIO_ENC_ONEHOT_EN
        .grant (grant_lsb),
`endif
        .valid (valid_lsb)
    );

`ifndef PRIO_ENC_ONEHOT_EN
    assign grant_msb = 8'h00;
    assign grant_lsb = 8'h00;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [7:0] v, input bit lsb);
        logic [2:0] idx;
        logic [7:0] g;
        bit         found;
        idx   = 3'd0;
        g     = 8'h00;
        found = 1'b0;
        if (lsb) begin
            for (int k = 0; k < 8; k++) begin
                if (!found && v[k]) begin
                    idx = 3'(k); found = 1'b1;
                end
            end
        end else begin
            for (int k = 7; k >= 0; k--) begin
                if (!found && v[k]) begin
                    idx = 3'(k); found = 1'b1;
                end
            end
        end
        if (found) g[idx] = 1'b1;
`ifndef PRIO_ENC_ONEHOT_EN
        g = 8'h00;
`endif
        return {found, idx, g};
    endfunction

    function automatic logic [11:0] obs_msb();
        return {valid_msb, i_msb, grant_msb};
    endfunction

    function automatic logic [11:0] obs_lsb();
        return {valid_lsb, i_lsb, grant_lsb};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed={v=%b i=%0d g=%h} expected={v=%b i=%0d g=%h}",
                   tag, obs[11], obs[10:8], obs[7:0], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    // Drive v, record expectations, then compare once the next edge has registered it.
    task automatic cycle(input string tag, input logic [7:0] v);
        logic [11:0] e;
        y = v;
        q_msb.push_back(model(v, 1'b0));
        q_lsb.push_back(model(v, 1'b1));
        @(posedge clk);
        #1;
        if (q_msb.size() == 0 || q_lsb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, q_msb.size());
        end else begin
            e = q_msb.pop_front();
            last_msb = e;
            chk({tag, "_msb"}, obs_msb(), e);
            e = q_lsb.pop_front();
            last_lsb = e;
            chk({tag, "_lsb"}, obs_lsb(), e);
        end
    endtask

    localparam logic [11:0] RST_EXP = 12'h000;

    initial begin
        logic [7:0] walk;
        logic [7:0] multi [4];
        n_cmp = 0;
        n_err = 0;
        multi[0] = 8'b10000011;
        multi[1] = 8'b00111000;
        multi[2] = 8'b00001111;
        multi[3] = 8'b01010101;

        rst_n = 1'b0;
        y     = 8'hFF;
        #2;
        chk("reset_msb", obs_msb(), RST_EXP);
        chk("reset_lsb", obs_lsb(), RST_EXP);
        @(posedge clk);
        #1;
        chk("reset_hold_msb", obs_msb(), RST_EXP);
        chk("reset_hold_lsb", obs_lsb(), RST_EXP);
        rst_n = 1'b1;

        cycle("post_reset_ff", 8'hFF);

        walk = 8'h01;
        for (int k = 0; k < 8; k++) begin
            cycle("walk", walk);
            walk = walk << 1;
        end
        cycle("zero", 8'h00);

        for (int k = 0; k < 4; k++) begin
            cycle("multi", multi[k]);
        end
        cycle("zero_after_multi", 8'h00);

        // Changing y between edges must not move the registered outputs.
        cycle("latency_a", 8'b00111000);
        y = 8'h01;
        #3;
        chk("latency_hold_msb", obs_msb(), last_msb);
        chk("latency_hold_lsb", obs_lsb(), last_lsb);
        cycle("latency_b", 8'h01);

        for (int n = 0; n < 1000; n++) begin
            cycle("random", 8'($urandom));
        end

        // Asynchronous reset in the middle of a cycle, no edge in between.
        cycle("pre_reset", 8'b11110000);
        y = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_msb", obs_msb(), RST_EXP);
        chk("mid_reset_lsb", obs_lsb(), RST_EXP);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("first_after_reset", 8'b01010101);
        cycle("final_zero", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
